int_sink_gateway: RTL and testbench

INT_SINK_GATEWAY -- requirements
Module: int_sink_gateway

---
 rtl/int_sink_gateway.sv | 130 +++++++++++++
 tb/tb_int_sink_gateway.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/int_sink_gateway.sv
// Interrupt sink gateway: synchronizes N asynchronous interrupt lines, tracks
// per-source pending/inflight state and offers one locked claim at a time.
// Optional build macro INT_SINK_EDGE_EN selects rising-edge triggering with a
// one-deep hold per source; when undefined, sources are level triggered.
module int_sink_gateway #(
   parameter int unsigned N           = 4,
   parameter int unsigned SYNC_STAGES = 2,
   localparam int unsigned IDW        = (N > 1) ? $clog2(N) : 1
) (
   input  logic           clock,
   input  logic           reset,
   input  logic [N-1:0]   auto_int_in,
   output logic           claim_valid,
   input  logic           claim_ready,
   output logic [IDW-1:0] claim_id,
   input  logic           complete_valid,
   input  logic [IDW-1:0] complete_id,
   output logic [N-1:0]   pending,
   output logic [N-1:0]   inflight
);

   logic [N-1:0]   sync_q [SYNC_STAGES];
   logic [N-1:0]   sync;
   logic [N-1:0]   pending_q, pending_d;
   logic [N-1:0]   inflight_q, inflight_d;
   logic           claim_valid_q, claim_valid_d;
   logic [IDW-1:0] claim_id_q, claim_id_d;
   logic [N-1:0]   set_pend;
   logic [N-1:0]   acc_sel;
   logic [N-1:0]   cmp_clr;
   logic           accept;
   logic [IDW-1:0] lowest_id;

   assign sync   = sync_q[SYNC_STAGES-1];
   assign accept = claim_valid_q & claim_ready;

   // Synchronizer chain, one column of flops per source
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      end else begin
         sync_q[0] <= auto_int_in;
         for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      end
   end

`ifdef INT_SINK_EDGE_EN
   logic [N-1:0] prev_q;
   logic [N-1:0] hold_q, hold_d;
   logic [N-1:0] rise;
   logic [N-1:0] hold_fire;

   assign rise      = sync & ~prev_q;
   // A held edge turns into a pending request once the source is no longer inflight
   assign hold_fire = hold_q & ~inflight_q & ~pending_q;
   assign set_pend  = (rise & ~pending_q & ~inflight_q) | hold_fire;

   // Hold captures at most one edge arriving while the source is inflight
   always_comb begin
      hold_d = (hold_q & ~hold_fire) | (rise & inflight_q);
   end

   // Edge detector and hold state
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         prev_q <= '0;
         hold_q <= '0;
      end else begin
         prev_q <= sync;
         hold_q <= hold_d;
      end
   end
`else
   assign set_pend = sync & ~pending_q & ~inflight_q;
`endif

   // Decode acceptance and completion; ids with no matching source are ignored
   always_comb begin
      acc_sel = '0;
      cmp_clr = '0;
      for (int i = 0; i < N; i++) begin
         acc_sel[i] = accept && (claim_id_q == IDW'(i));
         cmp_clr[i] = complete_valid && (complete_id == IDW'(i)) && inflight_q[i];
      end
   end

   // Lowest-index pending source, used when a new claim locks
   always_comb begin
      lowest_id = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (pending_q[i]) lowest_id = IDW'(i);
      end
   end

   // Next-state for pending, inflight and the claim lock
   always_comb begin
      pending_d     = (pending_q & ~acc_sel) | set_pend;
      inflight_d    = (inflight_q & ~cmp_clr) | acc_sel;
      claim_valid_d = claim_valid_q;
      claim_id_d    = claim_id_q;
      if (accept) begin
         claim_valid_d = 1'b0;
         claim_id_d    = '0;
      end else if (!claim_valid_q && (|pending_q)) begin
         claim_valid_d = 1'b1;
         claim_id_d    = lowest_id;
      end
   end

   // Registered state
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pending_q     <= '0;
         inflight_q    <= '0;
         claim_valid_q <= 1'b0;
         claim_id_q    <= '0;
      end else begin
         pending_q     <= pending_d;
         inflight_q    <= inflight_d;
         claim_valid_q <= claim_valid_d;
         claim_id_q    <= claim_id_d;
      end
   end

   assign claim_valid = claim_valid_q;
   assign claim_id    = claim_id_q;
   assign pending     = pending_q;
   assign inflight    = inflight_q;

endmodule

// File: tb/tb_int_sink_gateway.sv
// Self-checking bench for int_sink_gateway: main N=4 instance plus an N=3
// instance for out-of-range completion ids. Expected claim ids are queued
// when sources are raised and compared when the claim is accepted.
module tb_int_sink_gateway;

   logic       clock = 1'b0;
   logic       reset;
   logic [3:0] auto_int_in;
   logic       claim_valid, claim_ready;
   logic [1:0] claim_id;
   logic       complete_valid;
   logic [1:0] complete_id;
   logic [3:0] pending, inflight;

   logic [2:0] b_int;
   logic       b_valid, b_ready, b_cv;
   logic [1:0] b_id, b_cid;
   logic [2:0] b_pending, b_inflight;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_q[$];

   always #5 clock = ~clock;

   int_sink_gateway #(.N(4), .SYNC_STAGES(2)) dut (
      .clock          (clock),
      .reset          (reset),
      .auto_int_in    (auto_int_in),
      .claim_valid    (claim_valid),
      .claim_ready    (claim_ready),
      .claim_id       (claim_id),
      .complete_valid (complete_valid),
      .complete_id    (complete_id),
      .pending        (pending),
      .inflight       (inflight)
   );

   int_sink_gateway #(.N(3), .SYNC_STAGES(2)) dut_n3 (
      .clock          (clock),
      .reset          (reset),
      .auto_int_in    (b_int),
      .claim_valid    (b_valid),
      .claim_ready    (b_ready),
      .claim_id       (b_id),
      .complete_valid (b_cv),
      .complete_id    (b_cid),
      .pending        (b_pending),
      .inflight       (b_inflight)
   );

   task automatic check_val(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 'h%0h expected 'h%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   // Wait (bounded) for a claim, accept it and compare against the scoreboard
   task automatic accept_claim(input string tag);
      int budget = 20;
      int exp;
      while (!claim_valid && budget > 0) begin
         tick();
         budget--;
      end
      check_val({tag, "_valid"}, int'(claim_valid), 1);
      if (exp_q.size() == 0) begin
         check_val({tag, "_sb_empty"}, 1, 0);
      end else begin
         exp = exp_q.pop_front();
         check_val({tag, "_id"}, int'(claim_id), exp);
      end
      claim_ready = 1'b1;
      tick();
      claim_ready = 1'b0;
      check_val({tag, "_drop"}, int'(claim_valid), 0);
   endtask

   task automatic complete(input logic [1:0] id);
      complete_valid = 1'b1;
      complete_id    = id;
      tick();
      complete_valid = 1'b0;
      complete_id    = '0;
   endtask

   initial begin
      reset = 1'b0; auto_int_in = '0; claim_ready = 1'b0;
      complete_valid = 1'b0; complete_id = '0;
      b_int = '0; b_ready = 1'b0; b_cv = 1'b0; b_cid = '0;
      #12;
      check_val("rst_pending", int'(pending), 0);
      check_val("rst_valid", int'(claim_valid), 0);
      reset = 1'b1;
      tick(2);

      // Level latency and claim lock on source 2
      auto_int_in = 4'b0100;
      exp_q.push_back(2);
      tick(2);
      check_val("lat_e2_pending", int'(pending), 0);
      tick();
      check_val("lat_e3_pending", int'(pending), 4'b0100);
      check_val("lat_e3_valid", int'(claim_valid), 0);
      tick();
      check_val("lat_e4_valid", int'(claim_valid), 1);
      check_val("lat_e4_id", int'(claim_id), 2);
      tick(3);
      check_val("hold_valid", int'(claim_valid), 1);
      check_val("hold_pending", int'(pending), 4'b0100);

      // Lower-index source arrives while id 2 is locked
      auto_int_in = 4'b0101;
      exp_q.push_back(0);
      tick(3);
      check_val("lock_pending", int'(pending), 4'b0101);
      check_val("lock_id", int'(claim_id), 2);
      accept_claim("acc2");
      check_val("acc2_inflight", int'(inflight), 4'b0100);
      check_val("acc2_pending", int'(pending), 4'b0001);
      check_val("acc2_id_zero", int'(claim_id), 0);
      tick();
      check_val("next_valid", int'(claim_valid), 1);
      check_val("next_id", int'(claim_id), 0);
      accept_claim("acc0");
      check_val("acc0_inflight", int'(inflight), 4'b0101);
      auto_int_in = '0;
      tick(3);
      complete(2'd2);
      check_val("cmp2_inflight", int'(inflight), 4'b0001);
      complete(2'd0);
      check_val("cmp0_inflight", int'(inflight), 0);
      tick(2);
      check_val("idle_pending", int'(pending), 0);

      // Held source re-pends one edge after its completion edge
      auto_int_in = 4'b0010;
      exp_q.push_back(1);
      accept_claim("acc1");
      check_val("acc1_inflight", int'(inflight), 4'b0010);
      tick(3);
      check_val("held_no_repend", int'(pending), 0);
      complete(2'd1);
      check_val("cmp1_edge_pending", int'(pending), 0);
      check_val("cmp1_inflight", int'(inflight), 0);
      tick();
      check_val("cmp1_repend", int'(pending), 4'b0010);
      auto_int_in = '0;
      exp_q.push_back(1);
      accept_claim("acc1b");
      complete(2'd1);
      tick(3);
      check_val("clean_pending", int'(pending), 0);
      check_val("clean_inflight", int'(inflight), 0);

      // Completion of an id that is not inflight
      complete(2'd3);
      check_val("bad_cmp_inflight", int'(inflight), 0);
      check_val("bad_cmp_pending", int'(pending), 0);
      check_val("bad_cmp_valid", int'(claim_valid), 0);

`ifdef INT_SINK_EDGE_EN
      // Two edges while inflight collapse into a single re-pend
      auto_int_in = 4'b1000; tick(2); auto_int_in = '0;
      exp_q.push_back(3);
      accept_claim("e_acc3");
      check_val("e_inflight", int'(inflight), 4'b1000);
      repeat (2) begin
         auto_int_in = 4'b1000; tick(2); auto_int_in = '0; tick(2);
      end
      tick(3);
      check_val("e_no_pend", int'(pending), 0);
      complete(2'd3);
      check_val("e_cmp_edge", int'(pending), 0);
      tick();
      check_val("e_repend", int'(pending), 4'b1000);
      exp_q.push_back(3);
      accept_claim("e_acc3b");
      complete(2'd3);
      tick(6);
      check_val("e_one_only", int'(pending), 0);
`endif

      // Reset with pending=1010 and inflight=0001
      auto_int_in = 4'b0001;
      exp_q.push_back(0);
      accept_claim("pre_rst");
      auto_int_in = 4'b1010;
      tick(4);
      auto_int_in = '0;
      check_val("pre_rst_pending", int'(pending), 4'b1010);
      check_val("pre_rst_inflight", int'(inflight), 4'b0001);
      #2 reset = 1'b0;
      #1;
      check_val("rst_async_pending", int'(pending), 0);
      check_val("rst_async_inflight", int'(inflight), 0);
      check_val("rst_async_valid", int'(claim_valid), 0);
      check_val("rst_async_id", int'(claim_id), 0);
      exp_q.delete();
      tick();
      reset = 1'b1;
      tick(5);
      check_val("post_rst_pending", int'(pending), 0);
      check_val("post_rst_valid", int'(claim_valid), 0);

      // Input held high across reset re-pends after full latency
      auto_int_in = 4'b1000;
      tick(4);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      tick(2);
      check_val("rerst_e2", int'(pending), 0);
      tick();
      check_val("rerst_e3", int'(pending), 4'b1000);
      auto_int_in = '0;

      // N=3 instance: completion id 3 is out of range
      b_int = 3'b001;
      tick(4);
      check_val("n3_valid", int'(b_valid), 1);
      check_val("n3_id", int'(b_id), 0);
      b_ready = 1'b1; tick(); b_ready = 1'b0;
      b_int = '0;
      check_val("n3_inflight", int'(b_inflight), 3'b001);
      b_cv = 1'b1; b_cid = 2'd3; tick(); b_cv = 1'b0;
      check_val("n3_oor_inflight", int'(b_inflight), 3'b001);
      check_val("n3_oor_pending", int'(b_pending), 0);
      b_cv = 1'b1; b_cid = 2'd0; tick(); b_cv = 1'b0;
      check_val("n3_cmp0", int'(b_inflight), 0);

      check_val("sb_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
